// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared types and helpers for the HI/LO multiply/divide unit.
//   muldiv_op_t  - operation encoding carried from decode into exec
//   DIV_STEPS    - quotient bits produced per division, one per cycle
package muldiv_unit_pkg;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    function automatic logic isSignedOp(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic isDivOp(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Magnitude of a word; 0x80000000 maps to itself, which reads correctly as unsigned.
    function automatic logic [31:0] absVal(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: exec-stage request/response bundle for muldiv_unit.
//   master (exec/issuer): start, op, a, b, flush  ->  busy, done, hi, lo
//   slave  (muldiv_unit): the reverse directions
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic        start;
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_div_core.sv
// muldiv_unit_div_core: iterative restoring divider on unsigned magnitudes.
//   clk, reset            - clock, synchronous active-high reset
//   load                  - capture dividend/divisor, clear remainder and step counter
//   step                  - produce one quotient bit (MSB first)
//   dividend, divisor     - unsigned operands
//   quotient, remainder   - results, valid after DIV_STEPS steps
//   lastStep              - the current step is the final one
module muldiv_unit_div_core
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        lastStep
);
    logic [31:0]      remReg;
    logic [31:0]      quoReg;   // dividend bits shift out the top, quotient bits in the bottom
    logic [31:0]      divReg;
    logic [CNT_W-1:0] count;
    logic [32:0]      shifted;
    logic [32:0]      trial;
    logic             geq;

    assign shifted = {remReg, quoReg[31]};
    assign trial   = shifted - {1'b0, divReg};
    // Shifted value is below 2*divisor, so a set top bit guarantees the subtract fits;
    // otherwise bit 32 of the difference is the borrow.
    assign geq     = shifted[32] | ~trial[32];

    always_ff @(posedge clk) begin
        if (reset) begin
            remReg <= '0;
            quoReg <= '0;
            divReg <= '0;
            count  <= '0;
        end else if (load) begin
            remReg <= '0;
            quoReg <= dividend;
            divReg <= divisor;
            count  <= '0;
        end else if (step) begin
            remReg <= geq ? trial[31:0] : shifted[31:0];
            quoReg <= {quoReg[30:0], geq};
            count  <= count + 1'b1;
        end
    end

    assign quotient  = quoReg;
    assign remainder = remReg;
    assign lastStep  = (count == CNT_W'(DIV_STEPS - 1));
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit producing {hi, lo}.
//   clk, reset - clock, synchronous active-high reset
//   bus        - muldiv_unit_if.slave: start/op/a/b/flush in, busy/done/hi/lo out
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_MUL   | product formed, written to hi/lo at end of cycle
// ST_DIV   | one quotient bit per cycle (or divide-by-zero shortcut)
// ST_FIX   | apply quotient/remainder signs
// ST_DONE  | hi/lo valid, done pulse; may accept a new start
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} state_t;

    state_t      state, nextState;
    muldiv_op_t  opReg;
    logic [31:0] aReg, bReg, hiReg, loReg;
    logic        negQuo, negRem;
    logic        accept, divStep, lastStep;
    logic [31:0] quotient, remainder;
    logic [63:0] aExt, bExt, product, resultNext;

    assign accept  = (state == ST_IDLE || state == ST_DONE) && bus.start && !bus.flush;
    assign divStep = (state == ST_DIV) && (bReg != 32'd0) && !bus.flush;

    muldiv_unit_div_core u_divCore (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && isDivOp(bus.op)),
        .step      (divStep),
        .dividend  (absVal(bus.a, isSignedOp(bus.op))),
        .divisor   (absVal(bus.b, isSignedOp(bus.op))),
        .quotient  (quotient),
        .remainder (remainder),
        .lastStep  (lastStep)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (bus.flush) begin
            nextState = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start)          nextState = isDivOp(bus.op) ? ST_DIV : ST_MUL;
                    else                    nextState = ST_IDLE;
                end
                ST_MUL:                     nextState = ST_DONE;
                ST_DIV: begin
                    if (bReg == 32'd0)      nextState = ST_DONE;
                    else if (lastStep)      nextState = ST_FIX;
                end
                ST_FIX:                     nextState = ST_DONE;
                default:                    nextState = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
        bus.done = (state == ST_DONE);
    end

    // Low 64 bits of the extended product are correct for both signed and unsigned.
    assign aExt    = isSignedOp(opReg) ? {{32{aReg[31]}}, aReg} : {32'd0, aReg};
    assign bExt    = isSignedOp(opReg) ? {{32{bReg[31]}}, bReg} : {32'd0, bReg};
    assign product = aExt * bExt;

    always_comb begin
        resultNext = {hiReg, loReg};
        case (state)
            ST_MUL: resultNext = product;
            ST_DIV: resultNext = {aReg, 32'hFFFF_FFFF};
            ST_FIX: resultNext = {negRem ? (32'd0 - remainder) : remainder,
                                  negQuo ? (32'd0 - quotient)  : quotient};
            default: resultNext = {hiReg, loReg};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opReg  <= MD_MULT;
            aReg   <= '0;
            bReg   <= '0;
            negQuo <= 1'b0;
            negRem <= 1'b0;
            hiReg  <= '0;
            loReg  <= '0;
        end else begin
            if (accept) begin
                opReg  <= bus.op;
                aReg   <= bus.a;
                bReg   <= bus.b;
                negQuo <= isSignedOp(bus.op) && (bus.a[31] ^ bus.b[31]);
                negRem <= isSignedOp(bus.op) && bus.a[31];
            end
            if (nextState == ST_DONE) begin
                hiReg <= resultNext[63:32];
                loReg <= resultNext[31:0];
            end
        end
    end

    assign bus.hi = hiReg;
    assign bus.lo = loReg;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with a behavioural reference model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycle;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbQ[$];
    exp_t monE;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: cycle %0d got %h required %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] refModel(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MD_MULT:  return 64'(sx * sy);
            MD_MULTU: return 64'(ux * uy);
            MD_DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic int latency(input muldiv_op_t o, input logic [31:0] y);
        if (o == MD_MULT || o == MD_MULTU || y == 32'd0) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge; the start cycle is the current cyc value.
    task automatic startOp(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                           input bit push, output int c0);
        logic [63:0] r;
        exp_t e;
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        c0        = cyc;
        if (push) begin
            r       = refModel(o, x, y);
            e.hi    = r[63:32];
            e.lo    = r[31:0];
            e.cycle = c0 + latency(o, y);
            sbQ.push_back(e);
        end
        tick();
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!bus.done && n < 50) begin
            tick();
            n++;
        end
        if (!bus.done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: cycle %0d got no done within 50 cycles required done=1", name, cyc);
            sbQ.delete();
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sbQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: cycle %0d got done=1 required done=0", cyc);
            end else begin
                monE = sbQ.pop_front();
                chk("result_hi", bus.hi, monE.hi);
                chk("result_lo", bus.lo, monE.lo);
                chk("done_cycle", 32'(cyc), 32'(monE.cycle));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = MD_MULT;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        tick();

        // MULT -3 * 5
        startOp(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, c);
        chk("mult_busy_c1", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("mult_busy_c2", {31'd0, bus.busy}, 32'd0);
        chk("mult_done_c2", {31'd0, bus.done}, 32'd1);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFF1);
        tick();
        chk("idle_after_done", {31'd0, bus.done}, 32'd0);

        // MULTU max * max
        startOp(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, c);
        tick();
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);
        tick();

        // DIV -7 / 2
        startOp(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, c);
        chk("div_busy_c1", {31'd0, bus.busy}, 32'd1);
        repeat (32) tick();
        chk("div_busy_c33", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("div_busy_c34", {31'd0, bus.busy}, 32'd0);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        tick();

        // Signed overflow
        startOp(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, c);
        waitDone("ovf");
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'd0);
        tick();

        // DIVU by zero
        startOp(MD_DIVU, 32'd100, 32'd0, 1'b1, c);
        tick();
        chk("dz_done_c2", {31'd0, bus.done}, 32'd1);
        chk("dz_hi", bus.hi, 32'd100);
        chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
        tick();

        // DIVU 100 / 7 leaves hi=2, lo=14
        startOp(MD_DIVU, 32'd100, 32'd7, 1'b1, c);
        waitDone("divu");
        chk("divu_lo", bus.lo, 32'd14);
        chk("divu_hi", bus.hi, 32'd2);
        tick();

        // Flush in cycle 10; a MULT start in cycle 5 must be ignored
        startOp(MD_DIV, 32'd12345, 32'd17, 1'b0, c);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.op    = MD_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        tick();
        bus.start = 1'b0;
        chk("flush_busy_c6", {31'd0, bus.busy}, 32'd1);
        repeat (4) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy_c11", {31'd0, bus.busy}, 32'd0);
        repeat (3) tick();
        chk("flush_hi_hold", bus.hi, 32'd2);
        chk("flush_lo_hold", bus.lo, 32'd14);

        // Back-to-back: MULT issued in the DONE cycle of a DIVU
        startOp(MD_DIVU, 32'd1000, 32'd3, 1'b1, c);
        repeat (33) tick();
        chk("b2b_div_done", {31'd0, bus.done}, 32'd1);
        startOp(MD_MULT, 32'd7, 32'hFFFF_FFFA, 1'b1, c);
        chk("b2b_mul_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        chk("b2b_mul_done", {31'd0, bus.done}, 32'd1);
        chk("b2b_mul_lo", bus.lo, 32'hFFFF_FFD6);
        tick();

        // Reset in DIV cycle 20
        startOp(MD_DIV, 32'd99999, 32'd13, 1'b0, c);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;
        tick();

        // Randomized operations, sometimes chained into the DONE cycle
        for (int i = 0; i < 60; i++) begin
            startOp(muldiv_op_t'($urandom_range(0, 3)), randOperand(), randOperand(), 1'b1, c);
            waitDone("rand");
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        repeat (4) tick();
        chk("sb_empty", 32'(sbQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
